cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Shares one `cordic` core between NB_REQ independent requesters.
- Round-robin arbitration on the input side; each issued request's channel index is pushed into an in-order tag FIFO.
- Each core result is routed back to the channel at the FIFO head.
- Sits between the requester blocks and the `cordic` instance; valid/ready on every side.

Parameters:
- NB_REQ, 4, number of requester channels (2..8)
- FIFO_DEPTH, 8, max outstanding requests inside the core (power of 2, >= 2)
- IDX_W, $clog2(NB_REQ), tag width (derived, not overridden)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- req_re_i  input  NB_REQ*12  real parts, channel k at [12k+11:12k]
- req_im_i  input  NB_REQ*12  imaginary parts, same packing
- req_valid_i  input  NB_REQ  request valid per channel
- req_ready_o  output  NB_REQ  request accepted per channel
- res_amp_o  output  12  result amplitude (shared bus)
- res_phi_o  output  11  result phase (shared bus)
- res_valid_o  output  NB_REQ  result valid, one-hot to owning channel
- res_ready_i  input  NB_REQ  result ready per channel
- cor_re_o  output  12  to core re_i
- cor_im_o  output  12  to core im_i
- cor_valid_o  output  1  to core valid_i
- cor_ready_i  input  1  from core ready_o
- cor_amp_i  input  12  from core amp_o
- cor_phi_i  input  11  from core phi_o
- cor_valid_i  input  1  from core valid_o
- cor_ready_o  output  1  to core ready_i
- busy_o  output  1  at least one request outstanding
- err_o  output  1  sticky protocol error
- stat_clr_i  input  1  clear statistics counters
- stat_cnt_o  output  NB_REQ*16  per-channel grant counters

Behaviour:
- Reset (rst_i=0, async): priority pointer=0, lock flag=0, tag FIFO empty, err_o=0, counters=0.
- Combinational outputs under reset: all valid/ready outputs = 0; busy_o = 0.
- Handshake rules: a transfer occurs when valid & ready are both high on a clk_i edge. Requesters hold valid and data until accepted.
- Arbitration, unlocked: pick the first k with req_valid_i[k]=1, scanning from pointer upward with wrap (pointer, pointer+1, ..., NB_REQ-1, 0, ...).
- Issue:
  - cor_valid_o = grant exists & !fifo_full.
  - cor_re_o/cor_im_o = granted channel's data (0 when no grant).
  - req_ready_o[g] = cor_valid_o & cor_ready_i; all other bits 0.
  - Input path latency is 0 cycles (combinational mux).
- Lock:
  - If cor_valid_o=1 and cor_ready_i=0, register the granted index and set lock.
  - While locked, grant = locked index regardless of other requests (no grant switching mid-handshake).
  - Lock clears on the accepting transfer.
- On accept of channel g: push g into the tag FIFO; pointer <= (g+1) mod NB_REQ.
- Return path:
  - h = FIFO head.
  - res_valid_o[h] = cor_valid_i & !fifo_empty; other bits 0.
  - cor_ready_o = !fifo_empty & res_ready_i[h].
  - res_amp_o/res_phi_o = cor_amp_i/cor_phi_i, passed through.
  - On the return transfer, pop the FIFO. Return path latency is 0 cycles.
- Full FIFO: no issue even if a pop happens in the same cycle; the slot becomes usable next cycle. Push and pop in the same cycle when not full is allowed; the count is unchanged.
- Empty FIFO with cor_valid_i=1: cor_ready_o=0, no res_valid_o, err_o set (sticky until reset).
- busy_o = !fifo_empty (registered count != 0).
- Results stay in issue order, since the core is in-order.
- A requester whose res_ready_i is low stalls all returns (head-of-line blocking, by design).

Optional Feature:
- Macro CORDIC_ARB_STATS_EN.
- Defined: stat_cnt_o[16k+15:16k] increments on each accepted request of channel k. Counters saturate at 0xFFFF. stat_clr_i=1 zeroes all counters synchronously; clear wins over a same-cycle increment.
- Undefined: no counter logic; stat_cnt_o tied to 0, stat_clr_i ignored.

Test Plan:
- Reset: after rst_i low then high, with no valid inputs -> all req_ready_o=0, cor_valid_o=0, busy_o=0, err_o=0.
- Single channel: ch2 sends re=0x100, im=0x000 -> cor_re_o=0x100 in the same cycle. The core's result appears only on res_valid_o[2] with amp≈0x100 (within core tolerance), phi=0. busy_o returns to 0 afterwards.
- Fairness: all 4 channels valid continuously, cor_ready_i=1, results drained -> grant order 0,1,2,3,0,1,... Exactly 2 grants per channel over 8 accepts.
- Lock: ch1 and ch3 valid, cor_ready_i=0 for 3 cycles with pointer at 1, then ch0 raises valid -> cor_re_o stays at ch1 data and ch1 is accepted first when cor_ready_i rises.
- Full and back-pressure: res_ready_i=0, core keeps accepting -> exactly FIFO_DEPTH=8 accepts, then cor_valid_o=0. Releasing res_ready_i returns results in issue order with correct one-hot res_valid_o.
- Error and stats: force cor_valid_i=1 with an empty FIFO -> err_o=1 and it stays 1. With CORDIC_ARB_STATS_EN, 5 ch0 accepts -> stat_cnt_o[15:0]=5; a stat_clr_i pulse -> 0.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one cordic core among NB_REQ requesters; an in-order tag FIFO
// steers each core result back to its owner. Optional grant counters: define CORDIC_ARB_STATS_EN.
module cordic_arbiter #(
  parameter int  NB_REQ     = 4,
  parameter int  FIFO_DEPTH = 8,
  localparam int IDX_W      = $clog2(NB_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NB_REQ*12-1:0] req_re_i,
  input  logic [NB_REQ*12-1:0] req_im_i,
  input  logic [NB_REQ-1:0]    req_valid_i,
  output logic [NB_REQ-1:0]    req_ready_o,
  output logic [11:0]          res_amp_o,
  output logic [10:0]          res_phi_o,
  output logic [NB_REQ-1:0]    res_valid_o,
  input  logic [NB_REQ-1:0]    res_ready_i,
  output logic [11:0]          cor_re_o,
  output logic [11:0]          cor_im_o,
  output logic                 cor_valid_o,
  input  logic                 cor_ready_i,
  input  logic [11:0]          cor_amp_i,
  input  logic [10:0]          cor_phi_i,
  input  logic                 cor_valid_i,
  output logic                 cor_ready_o,
  output logic                 busy_o,
  output logic                 err_o,
  input  logic                 stat_clr_i,
  output logic [NB_REQ*16-1:0] stat_cnt_o
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int DW     = 12;

  logic [IDX_W-1:0]  ptr_r, lock_idx_r, grant_idx_s, scan_idx_s, cand_s, head_s;
  logic              lock_r, err_r, scan_hit_s, hit_s, grant_s, issue_s, pop_s;
  logic              full_s, empty_s, ret_ok_s;
  logic [IDX_W-1:0]  tag_mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    return (sum >= NB_REQ) ? IDX_W'(sum - NB_REQ) : IDX_W'(sum);
  endfunction

  assign full_s  = (count_r == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty_s = (count_r == '0);
  assign head_s  = tag_mem_r[rd_ptr_r];
  assign busy_o  = ~empty_s;
  assign err_o   = err_r;

  // First valid channel at or after the priority pointer, wrapping around.
  always_comb begin
    scan_hit_s = 1'b0;
    scan_idx_s = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand_s     = wrap_idx(ptr_r, i);
      hit_s      = ~scan_hit_s & req_valid_i[cand_s];
      scan_idx_s = hit_s ? cand_s : scan_idx_s;
      scan_hit_s = scan_hit_s | hit_s;
    end
  end

  // A stalled offer keeps its channel until the core takes it.
  assign grant_s     = rst_i & (lock_r | scan_hit_s);
  assign grant_idx_s = lock_r ? lock_idx_r : scan_idx_s;
  assign cor_valid_o = grant_s & ~full_s;
  assign issue_s     = cor_valid_o & cor_ready_i;
  assign cor_re_o    = grant_s ? req_re_i[int'(grant_idx_s)*DW +: DW] : 12'd0;
  assign cor_im_o    = grant_s ? req_im_i[int'(grant_idx_s)*DW +: DW] : 12'd0;

  assign ret_ok_s    = rst_i & ~empty_s;
  assign cor_ready_o = ret_ok_s & res_ready_i[head_s];
  assign pop_s       = cor_valid_i & cor_ready_o;
  assign res_amp_o   = cor_amp_i;
  assign res_phi_o   = cor_phi_i;

  // One-hot ready/valid decode toward the requesters.
  always_comb begin
    req_ready_o = '0;
    res_valid_o = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      req_ready_o[k] = issue_s & (grant_idx_s == IDX_W'(k));
      res_valid_o[k] = ret_ok_s & cor_valid_i & (head_s == IDX_W'(k));
    end
  end

  // Pointer, lock, FIFO pointers/count and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_r      <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      err_r      <= 1'b0;
    end else begin
      if (issue_s) begin
        ptr_r    <= wrap_idx(grant_idx_s, 1);
        lock_r   <= 1'b0;
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end else if (cor_valid_o) begin
        lock_r     <= 1'b1;
        lock_idx_r <= grant_idx_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      count_r <= count_r + (ADDR_W+1)'(issue_s) - (ADDR_W+1)'(pop_s);
      if (cor_valid_i & empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Tag storage: owner index of every request inside the core.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        tag_mem_r[d] <= '0;
      end
    end else if (issue_s) begin
      tag_mem_r[wr_ptr_r] <= grant_idx_s;
    end
  end

`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] stat_r [NB_REQ];

  // Saturating per-channel grant counters; clear beats a same-cycle grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NB_REQ; k++) begin
        stat_r[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < NB_REQ; k++) begin
        if (stat_clr_i) begin
          stat_r[k] <= 16'd0;
        end else if (req_ready_o[k] && (stat_r[k] != 16'hFFFF)) begin
          stat_r[k] <= stat_r[k] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    stat_cnt_o = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      stat_cnt_o[16*k +: 16] = stat_r[k];
    end
  end
`else
  logic unused_stat_s;
  assign unused_stat_s = stat_clr_i;
  assign stat_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: acts as the cordic core (amp=re, phi=im[10:0]) and predicts grants,
// lock behaviour and result routing from a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_cordic_arbiter;
  localparam int NB    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NB*12-1:0] req_re, req_im;
  logic [NB-1:0] req_valid, req_ready, res_valid, res_ready;
  logic [11:0] res_amp, c_re, c_im, c_amp;
  logic [10:0] res_phi, c_phi;
  logic c_valid, c_ready, c_vin, c_rout, busy, err, stat_clr;
  logic [NB*16-1:0] stat_cnt;

  cordic_arbiter #(.NB_REQ(NB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .req_re_i(req_re), .req_im_i(req_im),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .res_amp_o(res_amp),
    .res_phi_o(res_phi), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .cor_re_o(c_re), .cor_im_o(c_im), .cor_valid_o(c_valid), .cor_ready_i(c_ready),
    .cor_amp_i(c_amp), .cor_phi_i(c_phi), .cor_valid_i(c_vin), .cor_ready_o(c_rout),
    .busy_o(busy), .err_o(err), .stat_clr_i(stat_clr), .stat_cnt_o(stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [11:0] re; logic [11:0] im; } txn_t;
  txn_t outq[$];
  logic [11:0] ch_re[NB], ch_im[NB];
  bit   ch_v[NB];
  int   rr_ptr, lock_idx, m_stat[NB];
  bit   locked;
  int   errors = 0, checks = 0;
  int   e_g;
  bit   e_cvalid, e_issue, e_crout, e_pop;
  logic [NB-1:0] e_rvalid, e_rready;

  function automatic void model_eval();
    e_g = -1;
    if (locked) e_g = lock_idx;
    else for (int i = 0; i < NB; i++)
      if (e_g < 0 && ch_v[(rr_ptr + i) % NB]) e_g = (rr_ptr + i) % NB;
    e_cvalid = (e_g >= 0) && (outq.size() < DEPTH);
    e_issue  = e_cvalid && c_ready;
    e_rready = '0;
    if (e_issue) e_rready[e_g] = 1'b1;
    e_rvalid = '0;
    e_crout  = 1'b0;
    if (outq.size() > 0) begin
      e_rvalid[outq[0].ch] = c_vin;
      e_crout = res_ready[outq[0].ch];
    end
    e_pop = c_vin && e_crout;
  endfunction

  function automatic void model_commit();
    txn_t t;
    if (e_pop) void'(outq.pop_front());
    if (e_issue) begin
      t.ch = e_g; t.re = ch_re[e_g]; t.im = ch_im[e_g];
      outq.push_back(t);
      ch_v[e_g] = 1'b0;
      rr_ptr = (e_g + 1) % NB;
      locked = 1'b0;
      if (m_stat[e_g] < 65535) m_stat[e_g]++;
    end else if (e_cvalid) begin
      locked = 1'b1;
      lock_idx = e_g;
    end
    if (stat_clr) for (int k = 0; k < NB; k++) m_stat[k] = 0;
  endfunction

  function automatic logic [NB*16-1:0] exp_stats();
    logic [NB*16-1:0] v;
    v = '0;
`ifdef CORDIC_ARB_STATS_EN
    for (int k = 0; k < NB; k++) v[16*k +: 16] = 16'(m_stat[k]);
`endif
    return v;
  endfunction

  task automatic settle(input bit core_out, input bit force_vin = 1'b0);
    for (int k = 0; k < NB; k++) begin
      req_re[12*k +: 12] = ch_re[k];
      req_im[12*k +: 12] = ch_im[k];
      req_valid[k] = ch_v[k];
    end
    c_vin = (core_out && outq.size() > 0) || force_vin;
    c_amp = (outq.size() > 0) ? outq[0].re : 12'hABC;
    c_phi = (outq.size() > 0) ? outq[0].im[10:0] : 11'h155;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic new_req(input int k);
    ch_v[k] = 1'b1;
    ch_re[k] = 12'($urandom);
    ch_im[k] = 12'($urandom);
  endtask

  task automatic model_init();
    outq.delete();
    for (int k = 0; k < NB; k++) begin ch_v[k] = 1'b0; m_stat[k] = 0; end
    rr_ptr = 0; locked = 1'b0; lock_idx = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; c_ready = 1'b0; res_ready = '0; stat_clr = 1'b0;
    model_init();
    settle(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    model_init();
    for (int k = 0; k < NB; k++) new_req(k);
    c_ready = 1'b1; res_ready = '1; stat_clr = 1'b0;
    settle(1'b0, 1'b1);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL rst_cor_valid: got %b want 0", c_valid); end
    checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL rst_res_valid: got %b want 0000", res_valid); end
    checks++; if (c_rout !== 1'b0) begin errors++; $display("FAIL rst_cor_ready: got %b want 0", c_rout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    model_init();
    settle(1'b0);
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL post_rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL post_rst_cor_valid: got %b want 0", c_valid); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL post_rst_busy_err: got %b%b want 00", busy, err); end
  endtask

  task automatic test_single();
    apply_reset();
    c_ready = 1'b1; res_ready = '1;
    ch_v[2] = 1'b1; ch_re[2] = 12'h100; ch_im[2] = 12'h000;
    settle(1'b0);
    checks++; if (c_re !== 12'h100 || c_im !== 12'h000) begin errors++; $display("FAIL single_cor_data: got %h/%h want 100/000", c_re, c_im); end
    checks++; if (c_valid !== 1'b1 || req_ready !== 4'b0100) begin errors++; $display("FAIL single_issue: got v=%b rdy=%b want v=1 rdy=0100", c_valid, req_ready); end
    tick();
    settle(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    checks++; if (res_valid !== 4'b0100 || c_rout !== 1'b1) begin errors++; $display("FAIL single_route: got %b/%b want 0100/1", res_valid, c_rout); end
    checks++; if (res_amp !== 12'h100 || res_phi !== 11'h000) begin errors++; $display("FAIL single_result: got %h/%h want 100/000", res_amp, res_phi); end
    tick();
    settle(1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_fairness();
    int got[NB];
    logic [NB-1:0] want;
    apply_reset();
    c_ready = 1'b1; res_ready = '1;
    for (int k = 0; k < NB; k++) begin new_req(k); got[k] = 0; end
    for (int i = 0; i < 2*NB; i++) begin
      settle(1'b1);
      want = 4'b0001 << (i % NB);
      checks++; if (req_ready !== want) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, req_ready, want); end
      checks++; if (c_re !== ch_re[i % NB]) begin errors++; $display("FAIL fair_data[%0d]: got %h want %h", i, c_re, ch_re[i % NB]); end
      checks++; if (res_valid !== e_rvalid) begin errors++; $display("FAIL fair_ret[%0d]: got %b want %b", i, res_valid, e_rvalid); end
      for (int k = 0; k < NB; k++) if (req_ready[k]) got[k]++;
      tick();
      for (int k = 0; k < NB; k++) if (!ch_v[k]) new_req(k);
    end
    for (int k = 0; k < NB; k++) begin
      checks++; if (got[k] !== 2) begin errors++; $display("FAIL fair_count[%0d]: got %0d want 2", k, got[k]); end
    end
  endtask

  task automatic test_lock();
    apply_reset();
    c_ready = 1'b1; res_ready = '1;
    new_req(0); settle(1'b0); tick();
    settle(1'b1); tick();
    new_req(1); new_req(3); c_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(1'b0);
      checks++; if (c_re !== ch_re[1] || c_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL lock_hold[%0d]: got re=%h v=%b rdy=%b want re=%h v=1 rdy=0000", i, c_re, c_valid, req_ready, ch_re[1]); end
      tick();
    end
    new_req(0);
    settle(1'b0);
    checks++; if (c_re !== ch_re[1]) begin errors++; $display("FAIL lock_ch0_raise: got %h want %h", c_re, ch_re[1]); end
    tick();
    c_ready = 1'b1; settle(1'b0);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_accept1: got %b want 0010", req_ready); end
    tick();
    c_ready = 1'b0; settle(1'b0); tick();
    new_req(2); settle(1'b0);
    checks++; if (c_re !== ch_re[3] || req_ready !== 4'b0000) begin errors++; $display("FAIL lock_override: got re=%h rdy=%b want re=%h rdy=0000", c_re, req_ready, ch_re[3]); end
    tick();
    c_ready = 1'b1; settle(1'b0);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_accept3: got %b want 1000", req_ready); end
    tick();
    settle(1'b0);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_wrap: got %b want 0001", req_ready); end
    tick();
  endtask

  task automatic test_full();
    int acc;
    int guard;
    apply_reset();
    c_ready = 1'b1; res_ready = '0; acc = 0;
    for (int k = 0; k < NB; k++) new_req(k);
    for (int i = 0; i < 12; i++) begin
      settle(1'b0);
      checks++; if (req_ready !== e_rready) begin errors++; $display("FAIL full_grant[%0d]: got %b want %b", i, req_ready, e_rready); end
      if (req_ready !== 4'b0000) acc++;
      tick();
      for (int k = 0; k < NB; k++) if (!ch_v[k]) new_req(k);
    end
    checks++; if (acc !== DEPTH) begin errors++; $display("FAIL full_accepts: got %0d want %0d", acc, DEPTH); end
    settle(1'b0);
    checks++; if (c_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_stop: got v=%b busy=%b want v=0 busy=1", c_valid, busy); end
    tick();
    res_ready = ~(4'b0001 << outq[0].ch);
    settle(1'b1);
    checks++; if (res_valid !== e_rvalid || c_rout !== 1'b0) begin errors++; $display("FAIL hol_block: got %b/%b want %b/0", res_valid, c_rout, e_rvalid); end
    tick();
    res_ready = '1;
    settle(1'b1);
    checks++; if (c_rout !== 1'b1 || c_valid !== 1'b0) begin errors++; $display("FAIL full_pop_no_issue: got rdy=%b v=%b want rdy=1 v=0", c_rout, c_valid); end
    tick();
    settle(1'b0);
    checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL full_slot_reuse: got %b want 1", c_valid); end
    tick();
    c_ready = 1'b0; guard = 0;
    while (outq.size() > 0 && guard < 40) begin
      settle(1'b1);
      checks++; if (res_valid !== e_rvalid || res_amp !== outq[0].re) begin errors++; $display("FAIL drain_order[%0d]: got %b/%h want %b/%h", guard, res_valid, res_amp, e_rvalid, outq[0].re); end
      tick();
      guard++;
    end
    checks++; if (outq.size() != 0) begin errors++; $display("FAIL drain_timeout: got %0d left want 0", outq.size()); end
    settle(1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [11:0] want_re;
    apply_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int k = 0; k < NB; k++) if (!ch_v[k] && $urandom_range(0, 3) == 0) new_req(k);
      c_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NB; k++) res_ready[k] = ($urandom_range(0, 3) != 0);
      stat_clr = ($urandom_range(0, 49) == 0);
      settle($urandom_range(0, 2) != 0);
      want_re = 12'd0;
      if (e_g >= 0) want_re = ch_re[e_g];
      checks++; if (req_ready !== e_rready || c_valid !== e_cvalid) begin errors++; $display("FAIL rnd_issue[%0d]: got %b/%b want %b/%b", cyc, req_ready, c_valid, e_rready, e_cvalid); end
      checks++; if (c_re !== want_re) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, c_re, want_re); end
      checks++; if (res_valid !== e_rvalid || c_rout !== e_crout) begin errors++; $display("FAIL rnd_ret[%0d]: got %b/%b want %b/%b", cyc, res_valid, c_rout, e_rvalid, e_crout); end
      checks++; if (busy !== (outq.size() != 0) || err !== 1'b0) begin errors++; $display("FAIL rnd_busy_err[%0d]: got %b%b want %b0", cyc, busy, err, outq.size() != 0); end
      checks++; if (stat_cnt !== exp_stats()) begin errors++; $display("FAIL rnd_stats[%0d]: got %h want %h", cyc, stat_cnt, exp_stats()); end
      if (e_rvalid != '0) begin
        checks++; if (res_amp !== outq[0].re || res_phi !== outq[0].im[10:0]) begin errors++; $display("FAIL rnd_result[%0d]: got %h/%h want %h/%h", cyc, res_amp, res_phi, outq[0].re, outq[0].im[10:0]); end
      end
      tick();
    end
    stat_clr = 1'b0;
  endtask

  task automatic test_error();
    apply_reset();
    settle(1'b0, 1'b1);
    checks++; if (c_rout !== 1'b0 || res_valid !== 4'b0000) begin errors++; $display("FAIL err_no_route: got %b/%b want 0/0000", c_rout, res_valid); end
    tick();
    settle(1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    repeat (3) tick();
    settle(1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_stats();
    logic [15:0] want5;
`ifdef CORDIC_ARB_STATS_EN
    want5 = 16'd5;
`else
    want5 = 16'd0;
`endif
    apply_reset();
    c_ready = 1'b1; res_ready = '1;
    for (int i = 0; i < 5; i++) begin new_req(0); settle(1'b0); tick(); end
    settle(1'b0);
    checks++; if (stat_cnt[15:0] !== want5 || stat_cnt[NB*16-1:16] !== '0) begin errors++; $display("FAIL stats_count: got %h want %h", stat_cnt, {48'd0, want5}); end
    stat_clr = 1'b1; new_req(0);
    settle(1'b0); tick();
    stat_clr = 1'b0;
    settle(1'b0);
    checks++; if (stat_cnt !== '0) begin errors++; $display("FAIL stats_clear: got %h want 0", stat_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_full();
    test_random();
    test_error();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
